// File: rtl/par2ser_pkg.sv
// Shared types for the parallel-to-serial stream converter.
package par2ser_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } par2ser_state_e;

endpackage

// File: rtl/par2ser_stream.sv
// Parallel-to-serial converter with valid/ready on both sides, gapless
// back-to-back words, and a last-bit marker on the serial side.
module par2ser_stream
    import par2ser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             par_valid_i,
    output logic             par_ready_o,
    input  logic [WIDTH-1:0] par_data_i,
    output logic             ser_valid_o,
    output logic             ser_data_o,
    output logic             ser_last_o,
    input  logic             ser_ready_i,
    output logic             empty_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    par2ser_state_e   state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic at_last;
    logic accept;
    logic consume;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end

    // The output bit is taken from the shift register in every state, so it
    // reads 0 whenever the register has been cleared (IDLE).
    assign ser_data_o = LSB_FIRST ? sr_q[0] : sr_q[WIDTH-1];

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        at_last     = (cnt_q == CNT_LAST);
        ser_valid_o = (state_q == SHIFT);
        empty_o     = (state_q == IDLE);
        ser_last_o  = (state_q == SHIFT) && at_last;
        par_ready_o = !reset && ((state_q == IDLE) || (ser_ready_i && at_last));
        accept      = par_valid_i && par_ready_o;
        consume     = ser_valid_o && ser_ready_i;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    sr_d    = par_data_i;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (consume) begin
                    if (!at_last) begin
                        sr_d  = LSB_FIRST ? (sr_q >> 1) : (sr_q << 1);
                        cnt_d = cnt_q + 1'b1;
                    end else if (accept) begin
                        sr_d  = par_data_i;
                        cnt_d = '0;
                    end else begin
                        sr_d    = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                sr_d    = '0;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_par2ser_stream.sv
// Directed bench for par2ser_stream: LSB-first table plus MSB-first back-to-back sequence.
module tb_par2ser_stream;

    logic       clk;
    logic       reset;
    logic       par_valid;
    logic [3:0] par_data;
    logic       ser_ready;

    logic lsb_par_ready, lsb_ser_valid, lsb_ser_data, lsb_ser_last, lsb_empty;
    logic msb_par_ready, msb_ser_valid, msb_ser_data, msb_ser_last, msb_empty;

    int checks   = 0;
    int failures = 0;

    par2ser_stream #(.WIDTH(4), .LSB_FIRST(1'b1)) u_lsb (
        .clk         (clk),
        .reset       (reset),
        .par_valid_i (par_valid),
        .par_ready_o (lsb_par_ready),
        .par_data_i  (par_data),
        .ser_valid_o (lsb_ser_valid),
        .ser_data_o  (lsb_ser_data),
        .ser_last_o  (lsb_ser_last),
        .ser_ready_i (ser_ready),
        .empty_o     (lsb_empty)
    );

    par2ser_stream #(.WIDTH(4), .LSB_FIRST(1'b0)) u_msb (
        .clk         (clk),
        .reset       (reset),
        .par_valid_i (par_valid),
        .par_ready_o (msb_par_ready),
        .par_data_i  (par_data),
        .ser_valid_o (msb_ser_valid),
        .ser_data_o  (msb_ser_data),
        .ser_last_o  (msb_ser_last),
        .ser_ready_i (ser_ready),
        .empty_o     (msb_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs packed as {ser_valid, ser_data, ser_last, par_ready, empty}.
    typedef struct {
        logic       rst;
        logic       pv;
        logic [3:0] pd;
        logic       rdy;
        logic [4:0] exp;
        logic [4:0] mask;
        string      name;
    } vec_t;

    vec_t vq[$];

    task automatic step(input logic rst, input logic pv, input logic [3:0] pd, input logic rdy);
        @(posedge clk);
        #1;
        reset     = rst;
        par_valid = pv;
        par_data  = pd;
        ser_ready = rdy;
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp,
                         input logic [4:0] mask);
        checks++;
        if ((got & mask) !== (exp & mask)) begin
            failures++;
            $display("FAIL %s: got {valid,data,last,ready,empty}=%b required %b (mask %b)",
                     name, got, exp, mask);
        end
    endtask

    initial begin
        logic [4:0] msb_exp[10];

        reset     = 1'b1;
        par_valid = 1'b0;
        par_data  = 4'h0;
        ser_ready = 1'b1;

        //            rst   pv    pd     rdy   exp       mask      name
        vq.push_back('{1'b1, 1'b0, 4'h0, 1'b1, 5'b00001, 5'b11111, "rst_cycle0"});
        vq.push_back('{1'b1, 1'b0, 4'h0, 1'b1, 5'b00001, 5'b11111, "rst_cycle1"});
        vq.push_back('{1'b0, 1'b0, 4'h0, 1'b1, 5'b00011, 5'b11111, "idle_after_rst"});
        vq.push_back('{1'b0, 1'b1, 4'hB, 1'b1, 5'b00011, 5'b11111, "b_accept"});
        vq.push_back('{1'b0, 1'b0, 4'h0, 1'b1, 5'b11000, 5'b11111, "b_bit0"});
        vq.push_back('{1'b0, 1'b0, 4'h0, 1'b1, 5'b11000, 5'b11111, "b_bit1"});
        vq.push_back('{1'b0, 1'b0, 4'h0, 1'b1, 5'b10000, 5'b11111, "b_bit2"});
        vq.push_back('{1'b0, 1'b0, 4'h0, 1'b1, 5'b11110, 5'b11111, "b_bit3_last"});
        vq.push_back('{1'b0, 1'b0, 4'h0, 1'b1, 5'b00011, 5'b11111, "b_idle_after"});
        vq.push_back('{1'b0, 1'b1, 4'h6, 1'b1, 5'b00011, 5'b11111, "6_accept"});
        vq.push_back('{1'b0, 1'b0, 4'h0, 1'b1, 5'b10000, 5'b11111, "6_bit0"});
        vq.push_back('{1'b0, 1'b1, 4'hF, 1'b0, 5'b11000, 5'b11111, "6_stall0"});
        vq.push_back('{1'b0, 1'b1, 4'hF, 1'b0, 5'b11000, 5'b11111, "6_stall1"});
        vq.push_back('{1'b0, 1'b1, 4'hF, 1'b0, 5'b11000, 5'b11111, "6_stall2"});
        vq.push_back('{1'b0, 1'b0, 4'h0, 1'b1, 5'b11000, 5'b11111, "6_bit1"});
        vq.push_back('{1'b0, 1'b0, 4'h0, 1'b1, 5'b11000, 5'b11111, "6_bit2"});
        vq.push_back('{1'b0, 1'b0, 4'h0, 1'b1, 5'b10110, 5'b11111, "6_bit3_last"});
        vq.push_back('{1'b0, 1'b1, 4'hF, 1'b1, 5'b00011, 5'b11111, "f_accept"});
        vq.push_back('{1'b0, 1'b0, 4'h0, 1'b1, 5'b11000, 5'b11111, "f_bit0"});
        vq.push_back('{1'b0, 1'b0, 4'h0, 1'b1, 5'b11000, 5'b11111, "f_bit1"});
        vq.push_back('{1'b1, 1'b0, 4'h0, 1'b1, 5'b11000, 5'b00010, "f_rst_ready"});
        vq.push_back('{1'b0, 1'b0, 4'h0, 1'b1, 5'b00011, 5'b11111, "f_after_rst"});
        vq.push_back('{1'b0, 1'b1, 4'h3, 1'b1, 5'b00011, 5'b11111, "3_accept"});
        vq.push_back('{1'b0, 1'b0, 4'h0, 1'b1, 5'b11000, 5'b11111, "3_bit0"});
        vq.push_back('{1'b0, 1'b0, 4'h0, 1'b1, 5'b11000, 5'b11111, "3_bit1"});
        vq.push_back('{1'b0, 1'b0, 4'h0, 1'b1, 5'b10000, 5'b11111, "3_bit2"});
        vq.push_back('{1'b0, 1'b0, 4'h0, 1'b1, 5'b10110, 5'b11111, "3_bit3_last"});
        vq.push_back('{1'b0, 1'b0, 4'h0, 1'b0, 5'b00011, 5'b11111, "idle_rdy_low0"});
        vq.push_back('{1'b0, 1'b0, 4'h0, 1'b0, 5'b00011, 5'b11111, "idle_rdy_low1"});

        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].pv, vq[i].pd, vq[i].rdy);
            check(vq[i].name,
                  {lsb_ser_valid, lsb_ser_data, lsb_ser_last, lsb_par_ready, lsb_empty},
                  vq[i].exp, vq[i].mask);
        end

        // MSB-first back-to-back: 4'hA then 4'h5 -> 1,0,1,0,0,1,0,1 with no gap.
        step(1'b1, 1'b0, 4'h0, 1'b1);
        step(1'b1, 1'b0, 4'h0, 1'b1);
        check("msb_rst", {msb_ser_valid, msb_ser_data, msb_ser_last, msb_par_ready, msb_empty},
              5'b00001, 5'b11111);

        msb_exp[0] = 5'b00011;  // idle, A accepted
        msb_exp[1] = 5'b11000;  // A bit3 = 1
        msb_exp[2] = 5'b10000;  // A bit2 = 0
        msb_exp[3] = 5'b11000;  // A bit1 = 1
        msb_exp[4] = 5'b10110;  // A bit0 = 0, last, 5 accepted
        msb_exp[5] = 5'b10000;  // 5 bit3 = 0
        msb_exp[6] = 5'b11000;  // 5 bit2 = 1
        msb_exp[7] = 5'b10000;  // 5 bit1 = 0
        msb_exp[8] = 5'b11110;  // 5 bit0 = 1, last
        msb_exp[9] = 5'b00011;  // idle again

        for (int unsigned k = 0; k < 10; k++) begin
            if (k == 0)
                step(1'b0, 1'b1, 4'hA, 1'b1);
            else if (k < 5)
                step(1'b0, 1'b1, 4'h5, 1'b1);
            else
                step(1'b0, 1'b0, 4'h0, 1'b1);
            check($sformatf("msb_b2b_%0d", k),
                  {msb_ser_valid, msb_ser_data, msb_ser_last, msb_par_ready, msb_empty},
                  msb_exp[k], 5'b11111);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
